fpu_scoreboard: RTL and testbench
=================================

FPU_SCOREBOARD -- requirements
Module: fpu_scoreboard

Interface
REQ-001 SHALL have parameter NREG, 32, number of tracked GPRs.
REQ-002 SHALL have parameter MAXLAT, 4, largest result latency in cycles; countdowns are 3 bits wide.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port interlock  in  1  global pipeline freeze, the same signal that gates GPR writeback.
REQ-006 SHALL have ports u_issue_valid / l_issue_valid  in  1  upper/lower lane instruction in issue.
REQ-007 SHALL have ports u_rt / l_rt  in  5  destination register.
REQ-008 SHALL have ports u_lat / l_lat  in  3  result latency: 0 = no write, 1 = ALU/ftoi/itof/load, 2 = fadd/fsub/fmul/fsqrt, 4 = fdiv; 3 and >4 illegal.
REQ-009 SHALL have ports u_rs0, u_rs1, l_rs0, l_rs1  in  5  source registers.
REQ-010 SHALL have ports u_rs0_v, u_rs1_v, l_rs0_v, l_rs1_v  in  1  source is read.
REQ-011 SHALL have port issue_stall  out  1  hold the bundle in issue and insert a bubble.
REQ-012 SHALL have port busy  out  NREG  bit i set while GPR i has an outstanding write.
REQ-013 SHALL have port err  out  1  sticky illegal-issue flag.
REQ-014 SHALL have port stall_cycles  out  32  saturating count of hazard stall cycles.

Function
REQ-015 SHALL keep one 3-bit countdown cnt[i] per GPR; busy[i] = (cnt[i] != 0).
REQ-016 SHALL exclude GPR 0: no countdown kept, cnt[0] and busy[0] reads as 0, never a hazard source.
REQ-017 SHALL compute hazard combinationally as any valid source in either lane with busy set.
REQ-018 SHALL also raise hazard on WAW: a lane with lat != 0 whose rt has cnt[rt] > that lat.
REQ-019 SHALL drive issue_stall = hazard & (u_issue_valid | l_issue_valid).
REQ-020 SHALL accept a bundle at a rising edge only when interlock = 0 and issue_stall = 0.
REQ-021 SHALL accept each lane independently of the other; a lane is accepted only if its valid is 1.
REQ-022 SHALL load cnt[rt] with lat on acceptance of a lane with lat != 0 and rt != 0.
REQ-023 SHALL decrement every nonzero cnt not being loaded by 1 per edge while interlock = 0.
REQ-024 SHALL freeze all cnt, err and stall_cycles while interlock = 1, since writeback is frozen too.
REQ-025 SHALL give load priority over decrement on the same register in the same edge.
REQ-026 SHALL treat a register as readable in the cycle after its cnt reaches 0; there is no forwarding.
REQ-027 SHALL set err on acceptance when both lanes have lat != 0 and the same nonzero rt; the upper lane value is loaded.
REQ-028 SHALL set err on acceptance of a lane with lat of 3 or >4; lat = 4 is loaded in that case.
REQ-029 SHALL set err on acceptance when a lower-lane source equals a nonzero upper rt with u_lat != 0; the bundle is still accepted and no stall is caused.
REQ-030 SHALL increment stall_cycles, saturating at 32'hFFFF_FFFF, on each edge with issue_stall = 1 and interlock = 0.

Reset
REQ-031 SHALL, while rst = 1, immediately clear all cnt, busy, err and stall_cycles to 0, regardless of any in-flight operation.
REQ-032 SHALL output issue_stall = 0 after reset until a new write is accepted.
REQ-033 SHALL accept no issue on an edge where rst is high.

Verification
REQ-034 SHALL cover: upper fdiv, rt = 5, lat = 4, accepted at edge E0; next bundle reads r5 -> issue_stall = 1 for 4 cycles, cnt[5] = 3, 2, 1, 0, released after E4; stall_cycles = 4.
REQ-035 SHALL cover: lat = 2 to r7 accepted, interlock held high 3 cycles -> cnt[7] stays 2 throughout, then counts 1, 0 after release.
REQ-036 SHALL cover: r9 has cnt = 3, new issue lat = 1 to r9 -> WAW stall until cnt[9] <= 1, then accepted and cnt[9] = 1.
REQ-037 SHALL cover: both lanes lat = 2 to r3 -> err = 1, cnt[3] = 2; a later rt = 0 with lat = 4 -> busy stays 0.
REQ-038 SHALL cover: rst asserted mid-cycle with cnt[12] = 2 -> busy = 0 and issue_stall = 0 immediately, before the next edge.
REQ-039 SHALL cover: stall_cycles preset near 32'hFFFF_FFFF plus continued stalls -> saturates and does not wrap.

Source files
------------

// File: rtl/fpu_scoreboard.sv
// Register scoreboard for a dual-lane in-order issue stage: per-GPR result countdowns
// with RAW/WAW hazard detection, sticky illegal-issue flag and a saturating stall counter.
module fpu_scoreboard #(
  parameter int NREG   = 32,
  parameter int MAXLAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interlock,
  input  logic            u_issue_valid,
  input  logic            l_issue_valid,
  input  logic [4:0]      u_rt,
  input  logic [4:0]      l_rt,
  input  logic [2:0]      u_lat,
  input  logic [2:0]      l_lat,
  input  logic [4:0]      u_rs0,
  input  logic [4:0]      u_rs1,
  input  logic [4:0]      l_rs0,
  input  logic [4:0]      l_rs1,
  input  logic            u_rs0_v,
  input  logic            u_rs1_v,
  input  logic            l_rs0_v,
  input  logic            l_rs1_v,
  output logic            issue_stall,
  output logic [NREG-1:0] busy,
  output logic            err,
  output logic [31:0]     stall_cycles
);

  logic [2:0]  cnt_q [NREG];
  logic [2:0]  cnt_d [NREG];
  logic        err_d;
  logic [31:0] stall_d;
  logic        hazard;
  logic        accept, u_acc, l_acc, u_load, l_load;
  logic [2:0]  u_val, l_val;

  function automatic logic lat_legal(logic [2:0] lat);
    return (lat == 3'd1) || (lat == 3'd2) || (lat == 3'd4);
  endfunction

  always_comb begin
    busy = '0;
    for (int i = 1; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != 3'd0);
    end
  end

  // RAW on any read source, WAW when an older write would land after this one.
  always_comb begin
    hazard = 1'b0;
    if (u_rs0_v && busy[u_rs0]) hazard = 1'b1;
    if (u_rs1_v && busy[u_rs1]) hazard = 1'b1;
    if (l_rs0_v && busy[l_rs0]) hazard = 1'b1;
    if (l_rs1_v && busy[l_rs1]) hazard = 1'b1;
    if ((u_lat != 3'd0) && (cnt_q[u_rt] > u_lat)) hazard = 1'b1;
    if ((l_lat != 3'd0) && (cnt_q[l_rt] > l_lat)) hazard = 1'b1;
  end

  assign issue_stall = hazard & (u_issue_valid | l_issue_valid);
  assign accept      = ~interlock & ~issue_stall;
  assign u_acc       = accept & u_issue_valid;
  assign l_acc       = accept & l_issue_valid;
  assign u_load      = u_acc && (u_lat != 3'd0) && (u_rt != 5'd0);
  assign l_load      = l_acc && (l_lat != 3'd0) && (l_rt != 5'd0);
  assign u_val       = lat_legal(u_lat) ? u_lat : 3'(MAXLAT);
  assign l_val       = lat_legal(l_lat) ? l_lat : 3'(MAXLAT);

  // Upper lane is applied last so it wins a same-register collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!interlock && (cnt_q[i] != 3'd0)) cnt_d[i] = cnt_q[i] - 3'd1;
      if (l_load && (l_rt == 5'(i))) cnt_d[i] = l_val;
      if (u_load && (u_rt == 5'(i))) cnt_d[i] = u_val;
    end
    cnt_d[0] = 3'd0;
  end

  always_comb begin
    err_d = err;
    if (u_acc && l_acc && (u_lat != 3'd0) && (l_lat != 3'd0) && (u_rt == l_rt) &&
        (u_rt != 5'd0)) err_d = 1'b1;
    if (u_acc && (u_lat != 3'd0) && !lat_legal(u_lat)) err_d = 1'b1;
    if (l_acc && (l_lat != 3'd0) && !lat_legal(l_lat)) err_d = 1'b1;
    if (u_acc && l_acc && (u_lat != 3'd0) && (u_rt != 5'd0) &&
        ((l_rs0_v && (l_rs0 == u_rt)) || (l_rs1_v && (l_rs1 == u_rt)))) err_d = 1'b1;
  end

  always_comb begin
    stall_d = stall_cycles;
    if (issue_stall && !interlock && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_d = stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= 3'd0;
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      cnt_q        <= cnt_d;
      err          <= err_d;
      stall_cycles <= stall_d;
    end
  end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Self-checking bench for fpu_scoreboard: directed scenarios plus randomized issue traffic
// compared against a countdown-array reference model.
module tb_fpu_scoreboard;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic interlock, u_issue_valid, l_issue_valid;
  logic [4:0] u_rt, l_rt, u_rs0, u_rs1, l_rs0, l_rs1;
  logic [2:0] u_lat, l_lat;
  logic u_rs0_v, u_rs1_v, l_rs0_v, l_rs1_v;
  logic issue_stall, err;
  logic [NREG-1:0] busy;
  logic [31:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  int          mcnt [NREG];
  bit          merr;
  logic [31:0] mstall;

  fpu_scoreboard #(.NREG(NREG), .MAXLAT(4)) dut (
    .clk(clk), .rst(rst), .interlock(interlock),
    .u_issue_valid(u_issue_valid), .l_issue_valid(l_issue_valid),
    .u_rt(u_rt), .l_rt(l_rt), .u_lat(u_lat), .l_lat(l_lat),
    .u_rs0(u_rs0), .u_rs1(u_rs1), .l_rs0(l_rs0), .l_rs1(l_rs1),
    .u_rs0_v(u_rs0_v), .u_rs1_v(u_rs1_v), .l_rs0_v(l_rs0_v), .l_rs1_v(l_rs1_v),
    .issue_stall(issue_stall), .busy(busy), .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_lat(input logic [2:0] lat);
    return (lat == 3'd3 || lat > 3'd4) ? 4 : int'(lat);
  endfunction

  function automatic bit model_stall();
    bit h = 0;
    if (u_rs0_v && mcnt[u_rs0] > 0) h = 1;
    if (u_rs1_v && mcnt[u_rs1] > 0) h = 1;
    if (l_rs0_v && mcnt[l_rs0] > 0) h = 1;
    if (l_rs1_v && mcnt[l_rs1] > 0) h = 1;
    if (u_lat != 0 && mcnt[u_rt] > int'(u_lat)) h = 1;
    if (l_lat != 0 && mcnt[l_rt] > int'(l_lat)) h = 1;
    return h && (u_issue_valid || l_issue_valid);
  endfunction

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] b = '0;
    for (int i = 0; i < NREG; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) mcnt[i] = 0;
    merr = 0;
    mstall = 0;
  endtask

  // One rising edge of the reference: countdowns tick, accepted writes land, errors latch.
  task automatic model_edge(input bit st);
    int nxt [NREG];
    if (interlock) return;
    for (int i = 0; i < NREG; i++) nxt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
    if (!st) begin
      bit ul = u_issue_valid && u_lat != 0;
      bit ll = l_issue_valid && l_lat != 0;
      if (ll && l_rt != 0) nxt[l_rt] = eff_lat(l_lat);
      if (ul && u_rt != 0) nxt[u_rt] = eff_lat(u_lat);
      if (ul && ll && u_rt == l_rt && u_rt != 0) merr = 1;
      if (ul && eff_lat(u_lat) != int'(u_lat)) merr = 1;
      if (ll && eff_lat(l_lat) != int'(l_lat)) merr = 1;
      if (ul && l_issue_valid && u_rt != 0 &&
          ((l_rs0_v && l_rs0 == u_rt) || (l_rs1_v && l_rs1 == u_rt))) merr = 1;
    end else if (mstall != 32'hFFFF_FFFF) begin
      mstall = mstall + 1;
    end
    mcnt = nxt;
  endtask

  task automatic idle();
    interlock = 0; u_issue_valid = 0; l_issue_valid = 0;
    u_rt = 0; l_rt = 0; u_lat = 0; l_lat = 0;
    u_rs0 = 0; u_rs1 = 0; l_rs0 = 0; l_rs1 = 0;
    u_rs0_v = 0; u_rs1_v = 0; l_rs0_v = 0; l_rs1_v = 0;
  endtask

  // Inputs are applied after a falling edge; outputs are checked away from the rising edge.
  task automatic step();
    bit st;
    #1;
    st = model_stall();
    chk("issue_stall", issue_stall, st);
    @(posedge clk);
    model_edge(st);
    @(negedge clk);
    chk("busy", busy, model_busy());
    chk("err", err, merr);
    chk("stall_cycles", stall_cycles, mstall);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_clear();
    chk("rst_busy", busy, '0);
    chk("rst_issue_stall", issue_stall, 0);
    chk("rst_err", err, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_no_accept", busy, '0);
  endtask

  function automatic logic [2:0] rand_lat();
    int r = $urandom_range(0, 19);
    if (r < 5) return 3'd0;
    if (r < 10) return 3'd1;
    if (r < 15) return 3'd2;
    if (r < 18) return 3'd4;
    if (r == 18) return 3'd3;
    return 3'($urandom_range(5, 7));
  endfunction

  initial begin
    idle();
    model_clear();
    @(negedge clk);
    do_reset();

    // Upper fdiv to r5, then a reader of r5 waits four cycles.
    u_issue_valid = 1; u_rt = 5; u_lat = 4;
    step();
    chk("fdiv_busy5", busy[5], 1);
    idle(); l_issue_valid = 1; l_rs0 = 5; l_rs0_v = 1;
    repeat (4) step();
    step();
    chk("fdiv_stall_count", stall_cycles, 4);

    // Interlock freezes a lat-2 countdown on r7.
    idle(); u_issue_valid = 1; u_rt = 7; u_lat = 2;
    step();
    idle(); interlock = 1;
    repeat (3) begin
      step();
      chk("frz_busy7", busy[7], 1);
    end
    interlock = 0;
    step();
    chk("frz_busy7_c1", busy[7], 1);
    step();
    chk("frz_busy7_c0", busy[7], 0);

    // WAW: r9 at 3, new lat-1 write waits until the older write drains to 1.
    idle(); u_issue_valid = 1; u_rt = 9; u_lat = 4;
    step();
    idle();
    step();
    l_issue_valid = 1; l_rt = 9; l_lat = 1;
    repeat (3) step();
    chk("waw_stalls", stall_cycles, 6);
    chk("waw_busy9", busy[9], 1);
    idle();
    step();
    chk("waw_busy9_done", busy[9], 0);

    // Same-rt collision, then a write to r0 is ignored.
    idle(); u_issue_valid = 1; l_issue_valid = 1; u_rt = 3; l_rt = 3; u_lat = 2; l_lat = 2;
    step();
    chk("dup_err", err, 1);
    idle(); u_issue_valid = 1; u_rt = 0; u_lat = 4;
    step();
    chk("r0_busy", busy, 32'h0000_0008);
    idle();
    step();
    chk("r0_busy_clear", busy, '0);

    // Illegal latency loads the maximum.
    do_reset();
    u_issue_valid = 1; u_rt = 4; u_lat = 3;
    step();
    chk("illegal_err", err, 1);
    idle();
    repeat (3) step();
    chk("illegal_busy4", busy[4], 1);
    step();

    // Lower lane reads the upper lane's destination: accepted without a stall.
    do_reset();
    u_issue_valid = 1; u_rt = 6; u_lat = 1; l_issue_valid = 1; l_rs0 = 6; l_rs0_v = 1;
    step();
    chk("xlane_err", err, 1);
    chk("xlane_no_stall", stall_cycles, 0);

    // Mid-cycle reset with r12 outstanding and a reader waiting.
    do_reset();
    u_issue_valid = 1; u_rt = 12; u_lat = 2;
    step();
    idle(); l_issue_valid = 1; l_rs0 = 12; l_rs0_v = 1;
    #1;
    chk("pre_rst_stall", issue_stall, 1);
    #2;
    do_reset();

    // Saturation of the stall counter.
    idle();
    dut.stall_cycles = 32'hFFFF_FFFD;
    mstall = 32'hFFFF_FFFD;
    u_issue_valid = 1; u_rt = 5; u_lat = 4;
    step();
    idle(); l_issue_valid = 1; l_rs1 = 5; l_rs1_v = 1;
    repeat (4) step();
    chk("sat_value", stall_cycles, 32'hFFFF_FFFF);

    // Randomized traffic over a small register window to provoke hazards.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        idle();
        interlock     = ($urandom_range(0, 99) < 15);
        u_issue_valid = $urandom_range(0, 1);
        l_issue_valid = $urandom_range(0, 1);
        if (u_issue_valid) begin
          u_rt = 5'($urandom_range(0, 7)); u_lat = rand_lat();
          u_rs0 = 5'($urandom_range(0, 7)); u_rs0_v = $urandom_range(0, 1);
          u_rs1 = 5'($urandom_range(0, 7)); u_rs1_v = $urandom_range(0, 1);
        end
        if (l_issue_valid) begin
          l_rt = 5'($urandom_range(0, 7)); l_lat = rand_lat();
          l_rs0 = 5'($urandom_range(0, 7)); l_rs0_v = $urandom_range(0, 1);
          l_rs1 = 5'($urandom_range(0, 7)); l_rs1_v = $urandom_range(0, 1);
        end
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
